// File: rtl/branch_redirect_pkg.sv
`default_nettype none
// ============================================================================
// Module  : branch_redirect_pkg
// Purpose : Shared types and constants for the branch redirect controller.
//           Holds the controller state encoding, the default PC width and
//           the width of the post-redirect drain counter.
// Revision: 1.0  initial release
// ============================================================================
package branch_redirect_pkg;

    localparam int c_PC_W_DEFAULT = 8;
    localparam int c_DRAIN_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/branch_redirect_ctrl_mispredict_select.sv
`default_nettype none
// ============================================================================
// Module  : mispredict_select
// Purpose : Combinational per-slot mispredict detection and oldest-first
//           selection for the 2-wide execute stage. Slot 1 is older; when it
//           mispredicts, slot 2 is on the wrong path and is ignored.
// Ports   : valid1/2, isBranch1/2, PredictionE1/2, branch_taken1/2,
//           PCE1/2, PCPlus1E1/2, branchAdderResultE1/2   (inputs)
//           sel_valid  - a mispredict was selected
//           sel_slot1  - the selected mispredict is in slot 1
//           sel_pc     - PC of the selected branch
//           sel_target - corrected fetch PC for the selected branch
//           sel_taken  - resolved outcome of the selected branch
// Revision: 1.0  initial release
// ============================================================================
module mispredict_select
    import branch_redirect_pkg::*;
#(
    parameter int PC_W = c_PC_W_DEFAULT
) (
    input  logic            valid1,
    input  logic            valid2,
    input  logic            isBranch1,
    input  logic            isBranch2,
    input  logic            PredictionE1,
    input  logic            PredictionE2,
    input  logic            branch_taken1,
    input  logic            branch_taken2,
    input  logic [PC_W-1:0] PCE1,
    input  logic [PC_W-1:0] PCE2,
    input  logic [PC_W-1:0] PCPlus1E1,
    input  logic [PC_W-1:0] PCPlus1E2,
    input  logic [PC_W-1:0] branchAdderResultE1,
    input  logic [PC_W-1:0] branchAdderResultE2,
    output logic            sel_valid,
    output logic            sel_slot1,
    output logic [PC_W-1:0] sel_pc,
    output logic [PC_W-1:0] sel_target,
    output logic            sel_taken
);

    logic w_mis1;
    logic w_mis2;

    assign w_mis1 = valid1 & isBranch1 & (branch_taken1 ^ PredictionE1);
    assign w_mis2 = valid2 & isBranch2 & (branch_taken2 ^ PredictionE2);

    always_comb begin
        sel_valid  = 1'b0;
        sel_slot1  = 1'b0;
        sel_pc     = '0;
        sel_target = '0;
        sel_taken  = 1'b0;
        if (w_mis1) begin
            sel_valid  = 1'b1;
            sel_slot1  = 1'b1;
            sel_pc     = PCE1;
            sel_target = branch_taken1 ? branchAdderResultE1 : PCPlus1E1;
            sel_taken  = branch_taken1;
        end else if (w_mis2) begin
            sel_valid  = 1'b1;
            sel_pc     = PCE2;
            sel_target = branch_taken2 ? branchAdderResultE2 : PCPlus1E2;
            sel_taken  = branch_taken2;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : branch_redirect_ctrl
// Purpose : Misprediction recovery sequencer for the 2-wide execute stage.
//           Picks the oldest E-stage mispredict, issues a registered redirect
//           PC to fetch over a valid/ready handshake, pulses the pipeline
//           flushes and a predictor-update record, then ignores wrong-path
//           resolutions for DRAIN_CYCLES cycles after the redirect is taken.
// Config  : `define BRANCH_REDIRECT_PERF_EN adds the saturating 16-bit
//           perf_branches / perf_mispredicts counters and their ports.
// Ports   : clk, rst (async, active low)
//           E-stage slot 1/2 resolution inputs
//           redirect_ready / redirect_valid / redirect_pc  - fetch handshake
//           flush_FD, flush_E2                              - flush pulses
//           upd_valid, upd_pc, upd_taken                    - predictor update
//           busy                                            - not in IDLE
// Revision: 1.0  initial release
// ============================================================================
module branch_redirect_ctrl
    import branch_redirect_pkg::*;
#(
    parameter int PC_W         = c_PC_W_DEFAULT,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid1,
    input  logic            valid2,
    input  logic            isBranch1,
    input  logic            isBranch2,
    input  logic            PredictionE1,
    input  logic            PredictionE2,
    input  logic            branch_taken1,
    input  logic            branch_taken2,
    input  logic [PC_W-1:0] PCE1,
    input  logic [PC_W-1:0] PCE2,
    input  logic [PC_W-1:0] PCPlus1E1,
    input  logic [PC_W-1:0] PCPlus1E2,
    input  logic [PC_W-1:0] branchAdderResultE1,
    input  logic [PC_W-1:0] branchAdderResultE2,
    input  logic            redirect_ready,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush_FD,
    output logic            flush_E2,
    output logic            upd_valid,
    output logic [PC_W-1:0] upd_pc,
    output logic            upd_taken,
`ifdef BRANCH_REDIRECT_PERF_EN
    output logic [15:0]     perf_branches,
    output logic [15:0]     perf_mispredicts,
`endif
    output logic            busy
);

    localparam logic [c_DRAIN_CNT_W-1:0] c_CNT_LOAD = c_DRAIN_CNT_W'(DRAIN_CYCLES);
    localparam logic [c_DRAIN_CNT_W-1:0] c_CNT_ONE  = c_DRAIN_CNT_W'(1);

    logic            w_sel_valid;
    logic            w_sel_slot1;
    logic [PC_W-1:0] w_sel_pc;
    logic [PC_W-1:0] w_sel_target;
    logic            w_sel_taken;

    state_e                   r_state;
    state_e                   w_state_d;
    logic [c_DRAIN_CNT_W-1:0] r_cnt;
    logic [c_DRAIN_CNT_W-1:0] w_cnt_d;
    logic                     r_rv,        w_rv_d;
    logic [PC_W-1:0]          r_rpc,       w_rpc_d;
    logic                     r_flush_fd,  w_flush_fd_d;
    logic                     r_flush_e2,  w_flush_e2_d;
    logic                     r_upd_valid, w_upd_valid_d;
    logic [PC_W-1:0]          r_upd_pc,    w_upd_pc_d;
    logic                     r_upd_taken, w_upd_taken_d;

    mispredict_select #(
        .PC_W (PC_W)
    ) u_sel (
        .valid1              (valid1),
        .valid2              (valid2),
        .isBranch1           (isBranch1),
        .isBranch2           (isBranch2),
        .PredictionE1        (PredictionE1),
        .PredictionE2        (PredictionE2),
        .branch_taken1       (branch_taken1),
        .branch_taken2       (branch_taken2),
        .PCE1                (PCE1),
        .PCE2                (PCE2),
        .PCPlus1E1           (PCPlus1E1),
        .PCPlus1E2           (PCPlus1E2),
        .branchAdderResultE1 (branchAdderResultE1),
        .branchAdderResultE2 (branchAdderResultE2),
        .sel_valid           (w_sel_valid),
        .sel_slot1           (w_sel_slot1),
        .sel_pc              (w_sel_pc),
        .sel_target          (w_sel_target),
        .sel_taken           (w_sel_taken)
    );

    // Next-state and next-output logic. Flush/update outputs default to 0 so
    // they can only ever be high for the single cycle after detection.
    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_rv_d        = r_rv;
        w_rpc_d       = r_rpc;
        w_flush_fd_d  = 1'b0;
        w_flush_e2_d  = 1'b0;
        w_upd_valid_d = 1'b0;
        w_upd_pc_d    = '0;
        w_upd_taken_d = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sel_valid) begin
                    w_state_d     = REDIRECT;
                    w_rv_d        = 1'b1;
                    w_rpc_d       = w_sel_target;
                    w_flush_fd_d  = 1'b1;
                    w_flush_e2_d  = w_sel_slot1;
                    w_upd_valid_d = 1'b1;
                    w_upd_pc_d    = w_sel_pc;
                    w_upd_taken_d = w_sel_taken;
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    w_rv_d  = 1'b0;
                    w_rpc_d = '0;
                    if (DRAIN_CYCLES == 0) begin
                        w_state_d = IDLE;
                    end else begin
                        w_state_d = DRAIN;
                        w_cnt_d   = c_CNT_LOAD;
                    end
                end
            end
            DRAIN: begin
                w_cnt_d = r_cnt - c_CNT_ONE;
                if (r_cnt <= c_CNT_ONE) begin
                    w_state_d = IDLE;
                    w_cnt_d   = '0;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = '0;
                w_rv_d    = 1'b0;
                w_rpc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rv        <= 1'b0;
            r_rpc       <= '0;
            r_flush_fd  <= 1'b0;
            r_flush_e2  <= 1'b0;
            r_upd_valid <= 1'b0;
            r_upd_pc    <= '0;
            r_upd_taken <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_rv        <= w_rv_d;
            r_rpc       <= w_rpc_d;
            r_flush_fd  <= w_flush_fd_d;
            r_flush_e2  <= w_flush_e2_d;
            r_upd_valid <= w_upd_valid_d;
            r_upd_pc    <= w_upd_pc_d;
            r_upd_taken <= w_upd_taken_d;
        end
    end

    assign redirect_valid = r_rv;
    assign redirect_pc    = r_rpc;
    assign flush_FD       = r_flush_fd;
    assign flush_E2       = r_flush_e2;
    assign upd_valid      = r_upd_valid;
    assign upd_pc         = r_upd_pc;
    assign upd_taken      = r_upd_taken;
    assign busy           = (r_state != IDLE);

`ifdef BRANCH_REDIRECT_PERF_EN
    logic        w_br1;
    logic        w_br2;
    logic [16:0] w_br_sum;
    logic [16:0] w_mp_sum;
    logic [15:0] r_perf_br;
    logic [15:0] r_perf_mp;

    // A slot-2 branch behind a slot-1 mispredict is wrong-path, not resolved.
    assign w_br1    = valid1 & isBranch1;
    assign w_br2    = valid2 & isBranch2 & ~w_sel_slot1;
    assign w_br_sum = {1'b0, r_perf_br} + {16'd0, w_br1} + {16'd0, w_br2};
    assign w_mp_sum = {1'b0, r_perf_mp} + 17'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_br <= '0;
            r_perf_mp <= '0;
        end else if (r_state == IDLE) begin
            r_perf_br <= w_br_sum[16] ? 16'hFFFF : w_br_sum[15:0];
            if (w_sel_valid) begin
                r_perf_mp <= w_mp_sum[16] ? 16'hFFFF : w_mp_sum[15:0];
            end
        end
    end

    assign perf_branches    = r_perf_br;
    assign perf_mispredicts = r_perf_mp;
`endif

endmodule
`default_nettype wire
